// File: rtl/rv32i_pkg.sv
// Shared RV32I writeback definitions: load funct3 encodings and the load-queue entry.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } ld_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bus bundle between the writeback stage and its producers/consumers.
interface wb_stage_if;

  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_addr_lo;
  logic        ld_issue_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        hazard;
  logic        rsp_err;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_addr_lo,
    input  mem_rsp_valid, mem_rsp_data,
    input  chk_rs1, chk_rs2,
    output alu_ready, ld_issue_ready,
    output rf_wen, rf_rd, rf_wdata,
    output hazard, rsp_err
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_addr_lo,
    output mem_rsp_valid, mem_rsp_data,
    output chk_rs1, chk_rs2,
    input  alu_ready, ld_issue_ready,
    input  rf_wen, rf_rd, rf_wdata,
    input  hazard, rsp_err
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Load data extraction: picks the byte/halfword named by addr_lo and extends it per funct3.
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  byte_sel_s;
  logic [15:0] half_sel_s;

  // Lane select and sign/zero extension; unknown funct3 values fall back to a full word.
  always_comb begin
    byte_sel_s = 8'h00;
    half_sel_s = 16'h0000;
    data       = raw;
    case (addr_lo)
      2'd0:    byte_sel_s = raw[7:0];
      2'd1:    byte_sel_s = raw[15:8];
      2'd2:    byte_sel_s = raw[23:16];
      2'd3:    byte_sel_s = raw[31:24];
      default: byte_sel_s = raw[7:0];
    endcase
    if (addr_lo[1]) begin
      half_sel_s = raw[31:16];
    end else begin
      half_sel_s = raw[15:0];
    end
    case (funct3)
      F3_LB:   data = {{24{byte_sel_s[7]}}, byte_sel_s};
      F3_LH:   data = {{16{half_sel_s[15]}}, half_sel_s};
      F3_LW:   data = raw;
      F3_LBU:  data = {24'h000000, byte_sel_s};
      F3_LHU:  data = {16'h0000, half_sel_s};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: outstanding-load queue, load-over-ALU arbitration,
// registered register-file write port and load-use hazard detection.
module wb_stage
  import rv32i_pkg::*;
#(
  parameter int LDQ_DEPTH = 2
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);

  localparam int PW = $clog2(LDQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LDQ_DEPTH);

  ld_entry_t       q_r [LDQ_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic            empty_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            alu_take_s;
  ld_entry_t       head_s;
  ld_entry_t       push_entry_s;
  logic [31:0]     aligned_s;
  logic            sel_valid_s;
  logic [4:0]      sel_rd_s;
  logic [31:0]     sel_data_s;
  logic            hazard_s;
  logic [PW-1:0]   idx_s;

  assign empty_s    = (count_r == {CW{1'b0}});
  assign full_s     = (count_r == DEPTH_C);
  assign push_s     = bus.ld_issue_valid && !full_s;
  assign pop_s      = bus.mem_rsp_valid && !empty_s;
  assign alu_take_s = bus.alu_valid && !pop_s;
  assign head_s     = q_r[rd_ptr_r];

  assign push_entry_s.rd      = bus.ld_issue_rd;
  assign push_entry_s.funct3  = bus.ld_issue_funct3;
  assign push_entry_s.addr_lo = bus.ld_issue_addr_lo;

  assign bus.ld_issue_ready = !full_s;
  assign bus.alu_ready      = !pop_s;
  assign bus.hazard         = hazard_s;

  load_align u_align (
    .funct3  (head_s.funct3),
    .addr_lo (head_s.addr_lo),
    .raw     (bus.mem_rsp_data),
    .data    (aligned_s)
  );

  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Write-port arbitration: a popped load response always beats the ALU.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_rd_s    = 5'd0;
    sel_data_s  = 32'd0;
    if (pop_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = head_s.rd;
      sel_data_s  = aligned_s;
    end else if (alu_take_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = bus.alu_rd;
      sel_data_s  = bus.alu_data;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Hazard: walk live queue slots from the head, plus the write currently on the port.
  always_comb begin
    idx_s    = rd_ptr_r;
    hazard_s = bus.rf_wen && rd_hit(bus.rf_rd, bus.chk_rs1, bus.chk_rs2);
    for (int k = 0; k < LDQ_DEPTH; k++) begin
      idx_s    = rd_ptr_r + PW'(k);
      hazard_s = hazard_s | ((CW'(k) < count_r) && rd_hit(q_r[idx_s].rd, bus.chk_rs1, bus.chk_rs2));
    end
  end

  // Load queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        q_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        q_r[wr_ptr_r] <= push_entry_s;
        wr_ptr_r      <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered register-file port and sticky orphan-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_wen   <= 1'b0;
      bus.rf_rd    <= 5'd0;
      bus.rf_wdata <= 32'd0;
      bus.rsp_err  <= 1'b0;
    end else begin
      bus.rf_wen <= sel_valid_s && (sel_rd_s != 5'd0);
      if (sel_valid_s) begin
        bus.rf_rd    <= sel_rd_s;
        bus.rf_wdata <= sel_data_s;
      end
      if (bus.mem_rsp_valid && empty_s) begin
        bus.rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_wb_stage;
  import rv32i_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  wb_stage_if bus();

  wb_stage #(.LDQ_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.alu_valid        = 1'b0;
    bus.alu_rd           = 5'd0;
    bus.alu_data         = 32'd0;
    bus.ld_issue_valid   = 1'b0;
    bus.ld_issue_rd      = 5'd0;
    bus.ld_issue_funct3  = 3'd0;
    bus.ld_issue_addr_lo = 2'd0;
    bus.mem_rsp_valid    = 1'b0;
    bus.mem_rsp_data     = 32'd0;
    bus.chk_rs1          = 5'd0;
    bus.chk_rs2          = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    bus.ld_issue_valid   = 1'b1;
    bus.ld_issue_rd      = rd;
    bus.ld_issue_funct3  = f3;
    bus.ld_issue_addr_lo = lo;
  endtask

  // Reference extraction written as shifts and masks on the raw word.
  function automatic logic [31:0] align_ref(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] raw);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (32'd8 * 32'(lo))) & 32'h0000_00FF;
    h = (raw >> (32'd16 * 32'(lo[1]))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    bus.chk_rs1 = 5'd5;
    tick();
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata} !== 38'd0) begin bad++; $display("FAIL reset_rf got=%h exp=0", {bus.rf_wen, bus.rf_rd, bus.rf_wdata}); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.rsp_err); end
    total++; if (bus.ld_issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ldready got=%b exp=1", bus.ld_issue_ready); end
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL reset_aluready got=%b exp=1", bus.alu_ready); end
    total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", bus.hazard); end
    rst_n = 1'b1;
    bus.chk_rs1 = 5'd0;
  endtask

  task automatic test_lb();
    issue(5'd5, F3_LB, 2'd3);
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'h80FF_FFFF;
    #1;
    total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL lb_aluready got=%b exp=0", bus.alu_ready); end
    tick();
    bus.mem_rsp_valid = 1'b0;
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd5, 32'hFFFF_FF80}) begin bad++; $display("FAIL lb_write got=%h exp=%h", {bus.rf_wen, bus.rf_rd, bus.rf_wdata}, {1'b1, 5'd5, 32'hFFFF_FF80}); end
  endtask

  task automatic test_half();
    issue(5'd6, F3_LHU, 2'd2);
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'hBEEF_1234;
    tick();
    bus.mem_rsp_valid = 1'b0;
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd6, 32'h0000_BEEF}) begin bad++; $display("FAIL lhu_write got=%h exp=%h", {bus.rf_wen, bus.rf_rd, bus.rf_wdata}, {1'b1, 5'd6, 32'h0000_BEEF}); end
    issue(5'd6, F3_LH, 2'd2);
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd6, 32'hFFFF_BEEF}) begin bad++; $display("FAIL lh_write got=%h exp=%h", {bus.rf_wen, bus.rf_rd, bus.rf_wdata}, {1'b1, 5'd6, 32'hFFFF_BEEF}); end
  endtask

  task automatic test_arbitration();
    issue(5'd8, F3_LW, 2'd0);
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd = 5'd7;
    bus.alu_data = 32'h0000_1234;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'hCAFE_0001;
    #1;
    total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL arb_stall got=%b exp=0", bus.alu_ready); end
    tick();
    bus.mem_rsp_valid = 1'b0;
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd8, 32'hCAFE_0001}) begin bad++; $display("FAIL arb_load_first got=%h exp=%h", {bus.rf_wen, bus.rf_rd, bus.rf_wdata}, {1'b1, 5'd8, 32'hCAFE_0001}); end
    #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL arb_release got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd7, 32'h0000_1234}) begin bad++; $display("FAIL arb_alu_second got=%h exp=%h", {bus.rf_wen, bus.rf_rd, bus.rf_wdata}, {1'b1, 5'd7, 32'h0000_1234}); end
    tick();
    total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL arb_idle got=%b exp=0", bus.rf_wen); end
  endtask

  task automatic test_full_hazard();
    issue(5'd9, F3_LW, 2'd0);
    tick();
    issue(5'd10, F3_LW, 2'd0);
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.chk_rs1 = 5'd9;
    #1;
    total++; if (bus.ld_issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", bus.ld_issue_ready); end
    total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL haz_rs1_head got=%b exp=1", bus.hazard); end
    bus.chk_rs1 = 5'd0;
    bus.chk_rs2 = 5'd10;
    #1;
    total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL haz_rs2_tail got=%b exp=1", bus.hazard); end
    bus.chk_rs2 = 5'd11;
    #1;
    total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL haz_nomatch got=%b exp=0", bus.hazard); end
    bus.chk_rs1 = 5'd9;
    bus.chk_rs2 = 5'd0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'h1111_1111;
    tick();
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd9, 32'h1111_1111}) begin bad++; $display("FAIL full_rsp1 got=%h exp=%h", {bus.rf_wen, bus.rf_rd, bus.rf_wdata}, {1'b1, 5'd9, 32'h1111_1111}); end
    total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL haz_rf_port got=%b exp=1", bus.hazard); end
    bus.mem_rsp_data = 32'h2222_2222;
    tick();
    bus.mem_rsp_valid = 1'b0;
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd10, 32'h2222_2222}) begin bad++; $display("FAIL full_rsp2 got=%h exp=%h", {bus.rf_wen, bus.rf_rd, bus.rf_wdata}, {1'b1, 5'd10, 32'h2222_2222}); end
    tick();
    bus.chk_rs1 = 5'd9;
    bus.chk_rs2 = 5'd10;
    #1;
    total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL haz_drained got=%b exp=0", bus.hazard); end
    bus.chk_rs1 = 5'd0;
    bus.chk_rs2 = 5'd0;
  endtask

  task automatic test_rd0_and_err();
    bus.alu_valid = 1'b1;
    bus.alu_rd = 5'd0;
    bus.alu_data = 32'hDEAD_BEEF;
    tick();
    bus.alu_valid = 1'b0;
    total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL rd0_suppress got=%b exp=0", bus.rf_wen); end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'h1234_5678;
    #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL orphan_aluready got=%b exp=1", bus.alu_ready); end
    tick();
    bus.mem_rsp_valid = 1'b0;
    total++; if ({bus.rf_wen, bus.rsp_err} !== 2'b01) begin bad++; $display("FAIL orphan_rsp got=%b exp=01", {bus.rf_wen, bus.rsp_err}); end
    tick();
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.rsp_err); end
  endtask

  task automatic test_reset_mid();
    issue(5'd12, F3_LW, 2'd0);
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd = 5'd13;
    bus.alu_data = 32'h0000_0055;
    tick();
    bus.alu_valid = 1'b0;
    bus.chk_rs1 = 5'd12;
    #1;
    total++; if ({bus.rf_wen, bus.hazard} !== 2'b11) begin bad++; $display("FAIL pre_reset got=%b exp=11", {bus.rf_wen, bus.hazard}); end
    rst_n = 1'b0;
    #1;
    total++; if ({bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.rsp_err, bus.hazard} !== 40'd0) begin bad++; $display("FAIL async_reset got=%h exp=0", {bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.rsp_err, bus.hazard}); end
    #1;
    rst_n = 1'b1;
    bus.chk_rs1 = 5'd0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'hAAAA_5555;
    tick();
    bus.mem_rsp_valid = 1'b0;
    total++; if ({bus.rf_wen, bus.rsp_err} !== 2'b01) begin bad++; $display("FAIL flushed_rsp got=%b exp=01", {bus.rf_wen, bus.rsp_err}); end
  endtask

  task automatic test_random();
    ld_entry_t   mq[$];
    ld_entry_t   e;
    logic        exp_wen;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
    logic        exp_err;
    logic        hold;
    logic        pop;
    logic        exp_haz;
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_wen = 1'b0;
    exp_rd = 5'd0;
    exp_wd = 32'd0;
    exp_err = 1'b0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!hold) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd = 5'($urandom_range(0, 7));
        bus.alu_data = $urandom;
      end
      bus.ld_issue_valid = 1'($urandom_range(0, 1));
      bus.ld_issue_rd = 5'($urandom_range(0, 7));
      bus.ld_issue_funct3 = 3'($urandom_range(0, 7));
      bus.ld_issue_addr_lo = 2'($urandom_range(0, 3));
      if (mq.size() > 0) bus.mem_rsp_valid = ($urandom_range(0, 2) != 0);
      else bus.mem_rsp_valid = ($urandom_range(0, 40) == 0);
      bus.mem_rsp_data = $urandom;
      bus.chk_rs1 = 5'($urandom_range(0, 7));
      bus.chk_rs2 = 5'($urandom_range(0, 7));
      #1;
      pop = bus.mem_rsp_valid && (mq.size() > 0);
      exp_haz = exp_wen && (exp_rd != 5'd0) && (exp_rd == bus.chk_rs1 || exp_rd == bus.chk_rs2);
      foreach (mq[i]) begin
        if (mq[i].rd != 5'd0 && (mq[i].rd == bus.chk_rs1 || mq[i].rd == bus.chk_rs2)) exp_haz = 1'b1;
      end
      total++; if (bus.alu_ready !== !pop) begin bad++; $display("FAIL rnd_aluready cyc=%0d got=%b exp=%b", cyc, bus.alu_ready, !pop); end
      total++; if (bus.ld_issue_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_ldready cyc=%0d got=%b exp=%b", cyc, bus.ld_issue_ready, (mq.size() < DEPTH)); end
      total++; if (bus.hazard !== exp_haz) begin bad++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", cyc, bus.hazard, exp_haz); end
      if (bus.mem_rsp_valid && mq.size() == 0) exp_err = 1'b1;
      e.rd = bus.ld_issue_rd;
      e.funct3 = bus.ld_issue_funct3;
      e.addr_lo = bus.ld_issue_addr_lo;
      if (bus.ld_issue_valid && mq.size() < DEPTH) begin
        mq.push_back(e);
        if (pop) mq = mq;
      end
      exp_wen = 1'b0;
      if (pop) begin
        e = mq.pop_front();
        exp_wen = (e.rd != 5'd0);
        exp_rd = e.rd;
        exp_wd = align_ref(e.funct3, e.addr_lo, bus.mem_rsp_data);
      end else if (bus.alu_valid) begin
        exp_wen = (bus.alu_rd != 5'd0);
        exp_rd = bus.alu_rd;
        exp_wd = bus.alu_data;
      end
      hold = bus.alu_valid && pop;
      tick();
      total++; if (bus.rf_wen !== exp_wen) begin bad++; $display("FAIL rnd_wen cyc=%0d got=%b exp=%b", cyc, bus.rf_wen, exp_wen); end
      if (exp_wen) begin
        total++; if ({bus.rf_rd, bus.rf_wdata} !== {exp_rd, exp_wd}) begin bad++; $display("FAIL rnd_write cyc=%0d got=%h exp=%h", cyc, {bus.rf_rd, bus.rf_wdata}, {exp_rd, exp_wd}); end
      end
      total++; if (bus.rsp_err !== exp_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.rsp_err, exp_err); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_lb();
    test_half();
    test_arbitration();
    test_full_hazard();
    test_rd0_and_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I core: the single writer of `reg_file`, driving its `rd`/`wen`/`wdata` port. It merges single-cycle ALU results with data memory load responses. Load data is extracted and sign- or zero-extended per the load's funct3 and address. Up to two outstanding loads are tracked, and a load-use hazard flag is produced for the issue stage.

## Interface
Parameters:
- `LDQ_DEPTH`, default 2: outstanding-load queue depth; power of two, at least 2.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU result accepted this cycle; producer holds its inputs while low.
- `ld_issue_valid` in 1: load issued to memory this cycle.
- `ld_issue_rd` in 5: load destination register.
- `ld_issue_funct3` in 3: load funct3.
- `ld_issue_addr_lo` in 2: low bits of the load address.
- `ld_issue_ready` out 1: queue not full.
- `mem_rsp_valid` in 1: load data returned; in order, one per issued load.
- `mem_rsp_data` in 32: raw word from memory.
- `rf_wen` out 1, `rf_rd` out 5, `rf_wdata` out 32: register file write port; all registered.
- `chk_rs1` in 5, `chk_rs2` in 5: source registers of the instruction in issue.
- `hazard` out 1: a source register has a write not yet visible in the register file.
- `rsp_err` out 1: sticky flag; a response arrived with the queue empty.

## Operation
- Load queue is a FIFO of {rd, funct3, addr_lo}.
  - Push when `ld_issue_valid && ld_issue_ready`.
  - Pop when `mem_rsp_valid` and the queue is not empty.
  - A push into a full queue never happens, because `ld_issue_ready = !full` and `full` comes from the registered count. A simultaneous push and pop on a non-full queue leaves the count unchanged.
- Load alignment, using the head entry:
  - LB (000): sign-extend byte `addr_lo`.
  - LH (001): sign-extend halfword `addr_lo[1]`.
  - LW (010): full word.
  - LBU (100): zero-extend byte `addr_lo`.
  - LHU (101): zero-extend halfword `addr_lo[1]`.
  - Any other funct3 is treated as LW.
- Arbitration: a load response always wins the write port.
  - `alu_ready = !(mem_rsp_valid && !empty)`, which is combinational.
  - A stalled ALU result is written in a later cycle; it is never dropped.
- Write: the selected {rd, data} is registered into `rf_*`.
  - `rf_wen` is 1 only if a source was selected and rd != 0.
  - rd = 0 writes are suppressed, but the source is still consumed (pop or accept).
- Response with empty queue: ignored, no write, `rsp_err` sets and holds until reset.
- Hazard, combinational: `hazard` is 1 if either `chk_rs1` or `chk_rs2` is non-zero and matches one of:
  - any valid queue entry rd;
  - `rf_rd` while `rf_wen` is 1.

## Timing
- Reset values: `rf_wen` 0, `rf_rd` 0, `rf_wdata` 0, `rsp_err` 0, queue empty, so `ld_issue_ready` 1, `alu_ready` 1 and `hazard` 0.
- Latency: the source (ALU or response) is presented in cycle N; `rf_*` are valid in cycle N+1; the register file captures at the end of N+1.
- Issue to response may take zero extra cycles: a push at edge N lets a response be popped in cycle N+1.
- `rst_n` asserted mid-operation flushes the queue and clears `rf_wen` immediately (asynchronous reset). The register file contents are not touched.
- Pointers wrap modulo `LDQ_DEPTH`; the count is `$clog2(LDQ_DEPTH)+1` bits.

## Structure
- `rv32i_pkg` holds the load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`) and the `ld_entry_t` struct {rd, funct3, addr_lo}.
- Sub-module `load_align` (combinational): inputs funct3, addr_lo and raw word; output extended word.
- The queue, arbiter, output register and hazard compare live in `wb_stage`.

## Test plan
- Issue LB rd=5, addr_lo=3, then a response of 0x80FF_FFFF -> the next cycle shows `rf_wen`=1, `rf_rd`=5, `rf_wdata`=0xFFFF_FF80.
- Issue LHU rd=6, addr_lo=2, then a response of 0xBEEF_1234 -> `rf_wdata`=0x0000_BEEF. Issue LH with the same data -> `rf_wdata`=0xFFFF_BEEF.
- ALU rd=7, 0x1234 presented in the same cycle as a load response for rd=8 -> `alu_ready`=0; rd=8 is written first and rd=7 the cycle after; no value is lost.
- Issue two loads -> `ld_issue_ready`=0 while the queue is full. Set `chk_rs1` to the first load's rd -> `hazard`=1. After both responses and the final write, `hazard`=0.
- ALU write with rd=0 -> `rf_wen` stays 0. A response with the queue empty -> no write and `rsp_err`=1 until `rst_n` falls.
- Assert `rst_n` low with one load pending and `rf_wen`=1 -> outputs are 0 immediately. After release, a response triggers no write and sets `rsp_err`.
